// File: rtl/instr_mem_loader.sv
// Instruction memory loader: parses a byte stream (16-bit word count, then
// little-endian 32-bit words) into memory writes, holding the CPU in reset meanwhile.
module instr_mem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [1:0] {HDR0, HDR1, DATA, RUN} state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         idx_q, idx_d;
    logic [1:0]          lane_q, lane_d;
    logic [23:0]         asm_q, asm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;

    assign byte_ready = (state_q != RUN);
    assign cpu_reset  = (state_q != RUN);
    assign xfer       = byte_valid && byte_ready;
    assign mem_we     = we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign load_done  = done_q;
    assign load_error = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            HDR0: begin
                if (xfer) begin
                    cnt_d[7:0] = byte_in;
                    state_d    = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    cnt_d[15:8] = byte_in;
                    idx_d       = '0;
                    lane_d      = '0;
                    if ({1'b0, byte_in, cnt_q[7:0]} > DEPTH_L) err_d = 1'b1;
                    if ({byte_in, cnt_q[7:0]} == 16'd0) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: asm_d[7:0]   = byte_in;
                        2'd1: asm_d[15:8]  = byte_in;
                        2'd2: asm_d[23:16] = byte_in;
                        default: begin
                            // Words past DEPTH are still consumed but never written.
                            we_d    = ({1'b0, idx_q} < DEPTH_L);
                            waddr_d = idx_q[ADDR_W-1:0];
                            wdata_d = {byte_in, asm_q};
                            idx_d   = idx_q + 16'd1;
                            if (idx_q == cnt_q - 16'd1) begin
                                state_d = RUN;
                                done_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                if (start) begin
                    state_d = HDR0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HDR0;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
